// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use stalls, branch squash and
// multiply/divide issue/wait with a hang timeout.
module hazard_ctrl #(
   parameter int unsigned LD_CYC     = 1,
   parameter int unsigned MD_TIMEOUT = 64,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_read_ex,
   input  logic [2:0]       dst_ex,
   input  logic [2:0]       rs_id,
   input  logic [2:0]       rt_id,
   input  logic             uses_rt_id,
   input  logic             branch_taken_ex,
   input  logic             md_op_ex,
   input  logic             md_done,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             md_go,
   output logic             md_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StLdStall = 2'd1,
      StMdWait  = 2'd2
   } state_t;

   localparam logic [3:0]       LdInit = 4'(LD_CYC - 1);
   localparam logic [7:0]       MdLast = 8'(MD_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [3:0]       ld_cnt_q, ld_cnt_d;
   logic [7:0]       md_tmr_q, md_tmr_d;
   logic             md_err_q, md_err_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic             luh;

   assign luh = mem_read_ex && (dst_ex != 3'd0) &&
                ((dst_ex == rs_id) || (uses_rt_id && (dst_ex == rt_id)));

   always_comb begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      md_go       = 1'b0;
      state_d     = state_q;
      ld_cnt_d    = ld_cnt_q;
      md_tmr_d    = md_tmr_q;
      md_err_d    = md_err_q;

      unique case (state_q)
         StRun: begin
            // A taken branch squashes the wrong-path ID instruction, so its hazards are moot.
            if (branch_taken_ex) begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (md_op_ex) begin
               md_go    = 1'b1;
               pc_en    = 1'b0;
               if_id_en = 1'b0;
               id_ex_en = 1'b0;
               state_d  = StMdWait;
               md_tmr_d = 8'd0;
            end else if (luh) begin
               pc_en       = 1'b0;
               if_id_en    = 1'b0;
               id_ex_flush = 1'b1;
               if (LD_CYC > 1) begin
                  state_d  = StLdStall;
                  ld_cnt_d = LdInit;
               end
            end
         end
         StLdStall: begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            ld_cnt_d    = ld_cnt_q - 4'd1;
            if (ld_cnt_q == 4'd1) state_d = StRun;
         end
         StMdWait: begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            md_tmr_d = md_tmr_q + 8'd1;
            if (md_done || (md_tmr_q == MdLast)) begin
               pc_en    = 1'b1;
               if_id_en = 1'b1;
               id_ex_en = 1'b1;
               state_d  = StRun;
               // Done wins over a coincident timeout.
               if (!md_done) md_err_d = 1'b1;
            end
         end
         default: state_d = StRun;
      endcase

      if (!rst_n) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_en    = 1'b0;
         if_id_flush = 1'b0;
         id_ex_flush = 1'b0;
         md_go       = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         ld_cnt_q    <= 4'd0;
         md_tmr_q    <= 8'd0;
         md_err_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         ld_cnt_q <= ld_cnt_d;
         md_tmr_q <= md_tmr_d;
         md_err_q <= md_err_d;
         if (!pc_en && (stall_cnt_q != CntMax)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign md_err    = md_err_q;
   assign stall_cnt = stall_cnt_q;
   assign state_o   = state_q;

endmodule
